// File: rtl/ethernet_tx_engine_if.sv
// Bus between the frame-transmit engine (master) and the DM9000-style controller (slave).
interface ethernet_tx_engine_if;
  logic [31:0] bus_address;
  logic        bus_write;
  logic        bus_read;
  logic [31:0] bus_data_wr;
  logic [31:0] bus_data_rd;
  logic        bus_stall;

  modport master (
    output bus_address,
    output bus_write,
    output bus_read,
    output bus_data_wr,
    input  bus_data_rd,
    input  bus_stall
  );

  modport slave (
    input  bus_address,
    input  bus_write,
    input  bus_read,
    input  bus_data_wr,
    output bus_data_rd,
    output bus_stall
  );
endinterface

// File: rtl/ethernet_tx_engine.sv
// Frame-transmit sequencer: streams halfwords into the controller's TX FIFO, programs the
// length, raises TXREQ and polls TCR until the controller reports the frame sent.
module ethernet_tx_engine #(
  parameter logic [31:0] BASE_ADDR  = 32'h1C03_0000,
  parameter int          MAX_LEN    = 1536,
  parameter int          POLL_LIMIT = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  input  logic [15:0]                 cmd_len,
  output logic                        cmd_ready,
  input  logic [15:0]                 s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  ethernet_tx_engine_if.master        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [3:0]                  dbg_state
);

  // Handshakes: cmd and stream transfer on a clock edge where valid & ready are both high.
  // Bus: request and address/data are held until the slave has stalled for >=1 cycle and then
  // released the stall; that edge completes the access and the request drops one cycle later.

  localparam int PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    MWCMD_IDX = 4'd1,
    DATA      = 4'd2,
    TXPLL_IDX = 4'd3,
    TXPLL_WR  = 4'd4,
    TXPLH_IDX = 4'd5,
    TXPLH_WR  = 4'd6,
    TCR_IDX   = 4'd7,
    TCR_WR    = 4'd8,
    POLL_IDX  = 4'd9,
    POLL_RD   = 4'd10,
    DONE      = 4'd11
  } state_t;

  state_t         state;
  state_t         next_st;
  logic [15:0]    len;
  logic [15:0]    hw_cnt;
  logic [PW-1:0]  poll_cnt;
  logic           fail_flag;
  logic           seen_stall;
  logic           pending;
  logic           complete;
  logic           bad_len;
  logic           req_data_port;
  logic [15:0]    req_word;

  assign pending   = bus.bus_write | bus.bus_read;
  assign complete  = pending & ~bus.bus_stall & seen_stall;
  assign s_ready   = (state == DATA) & ~pending;
  assign dbg_state = state;
  assign bad_len   = (cmd_len == 16'd0) || (cmd_len > 16'(MAX_LEN));

  // Register-programming steps: which port, what word, and where to go once it completes.
  always_comb begin
    req_data_port = 1'b0;
    req_word      = 16'h0000;
    next_st       = state;
    case (state)
      MWCMD_IDX: begin req_word = 16'h00F8; next_st = DATA; end
      TXPLL_IDX: begin req_word = 16'h00FC; next_st = TXPLL_WR; end
      TXPLL_WR: begin
        req_data_port = 1'b1;
        req_word      = {8'h00, len[7:0]};
        next_st       = TXPLH_IDX;
      end
      TXPLH_IDX: begin req_word = 16'h00FD; next_st = TXPLH_WR; end
      TXPLH_WR: begin
        req_data_port = 1'b1;
        req_word      = {8'h00, len[15:8]};
        next_st       = TCR_IDX;
      end
      TCR_IDX: begin req_word = 16'h0002; next_st = TCR_WR; end
      TCR_WR: begin
        req_data_port = 1'b1;
        req_word      = 16'h0001;
        next_st       = POLL_IDX;
      end
      POLL_IDX: begin req_word = 16'h0002; next_st = POLL_RD; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cmd_ready       <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      bus.bus_address <= 32'h0;
      bus.bus_data_wr <= 32'h0;
      bus.bus_write   <= 1'b0;
      bus.bus_read    <= 1'b0;
      len             <= 16'h0;
      hw_cnt          <= 16'h0;
      poll_cnt        <= '0;
      fail_flag       <= 1'b0;
      seen_stall      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (pending && bus.bus_stall) seen_stall <= 1'b1;
      if (complete) begin
        bus.bus_write <= 1'b0;
        bus.bus_read  <= 1'b0;
        seen_stall    <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (bad_len) begin
              err <= 1'b1;
            end else begin
              len       <= cmd_len;
              hw_cnt    <= (cmd_len >> 1) + {15'h0, cmd_len[0]};
              poll_cnt  <= '0;
              fail_flag <= 1'b0;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              state     <= MWCMD_IDX;
            end
          end
        end
        DATA: begin
          if (!pending && s_valid) begin
            bus.bus_address <= BASE_ADDR | 32'd1;
            bus.bus_data_wr <= {16'h0000, s_data};
            bus.bus_write   <= 1'b1;
            seen_stall      <= 1'b0;
            hw_cnt          <= hw_cnt - 16'd1;
            // s_last must land exactly on the final counted halfword.
            if (s_last != (hw_cnt == 16'd1)) fail_flag <= 1'b1;
          end else if (complete && hw_cnt == 16'd0) begin
            state <= TXPLL_IDX;
          end
        end
        POLL_RD: begin
          if (!pending) begin
            bus.bus_address <= BASE_ADDR | 32'd1;
            bus.bus_read    <= 1'b1;
            seen_stall      <= 1'b0;
          end else if (complete) begin
            if (!bus.bus_data_rd[0]) begin
              state <= DONE;
            end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
              fail_flag <= 1'b1;
              state     <= DONE;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          done      <= 1'b1;
          err       <= fail_flag;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        MWCMD_IDX, TXPLL_IDX, TXPLL_WR, TXPLH_IDX, TXPLH_WR, TCR_IDX, TCR_WR, POLL_IDX: begin
          if (!pending) begin
            bus.bus_address <= req_data_port ? (BASE_ADDR | 32'd1) : BASE_ADDR;
            bus.bus_data_wr <= {16'h0000, req_word};
            bus.bus_write   <= 1'b1;
            seen_stall      <= 1'b0;
          end else if (complete) begin
            state <= next_st;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_tx_engine.sv
// Directed bench for ethernet_tx_engine: stalling slave model, transaction log, frame scenarios.
module tb_ethernet_tx_engine;
  localparam logic [31:0] BASE = 32'h1C03_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_len = 16'h0;
  logic        cmd_ready;
  logic [15:0] s_data = 16'h0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        busy, done, err;
  logic [3:0]  dbg_state;

  ethernet_tx_engine_if bus_if();

  ethernet_tx_engine #(.BASE_ADDR(BASE), .MAX_LEN(1536), .POLL_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .bus(bus_if),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall_cycles = 1;
  bit rd_stuck = 1'b0;
  logic [15:0] rd_q[$];
  logic [15:0] hw_q[$];
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int done_cnt = 0, err_cnt = 0, req_cnt = 0, proto_bad = 0;
  bit active = 1'b0;
  int cnt = 0;
  logic [31:0] held_addr, held_data;
  logic held_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave: acks a new request with stall_cycles of bus_stall, logs {read, addr[0], data}.
  initial begin
    bus_if.bus_stall = 1'b0;
    bus_if.bus_data_rd = 32'h0;
    forever begin
      @(negedge clk);
      if (rst || !(bus_if.bus_write || bus_if.bus_read)) begin
        active = 1'b0;
        bus_if.bus_stall = 1'b0;
      end else if (!active) begin
        active = 1'b1;
        bus_if.bus_stall = 1'b1;
        cnt = stall_cycles;
        req_cnt++;
        held_addr = bus_if.bus_address;
        held_data = bus_if.bus_data_wr;
        held_wr = bus_if.bus_write;
        if (bus_if.bus_address[31:1] != BASE[31:1]) proto_bad++;
        if (bus_if.bus_write && bus_if.bus_read) proto_bad++;
        if (bus_if.bus_write && bus_if.bus_data_wr[31:16] != 16'h0) proto_bad++;
        obs_q.push_back({bus_if.bus_read, bus_if.bus_address[0],
                         bus_if.bus_read ? 16'h0 : bus_if.bus_data_wr[15:0]});
        if (bus_if.bus_read)
          bus_if.bus_data_rd = rd_stuck ? 32'h1 : (rd_q.size() > 0 ? {16'h0, rd_q.pop_front()} : 32'h0);
      end else begin
        if (bus_if.bus_address != held_addr || bus_if.bus_write != held_wr ||
            (held_wr && bus_if.bus_data_wr != held_data)) proto_bad++;
        if (cnt > 1) cnt--;
        else bus_if.bus_stall = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [15:0] l);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_hw(input logic [15:0] d, input logic last, input int max_gap);
    int n, b;
    n = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (n) @(negedge clk);
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    b = 0;
    #1;
    while (!s_ready && b < 2000) begin
      @(negedge clk);
      #1;
      b++;
    end
    if (b >= 2000) check("s_ready_timeout", 32'(b), 32'(0));
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] l, input int gap,
                           input int last_at, input int nreads, input int err_exp);
    int d0, e0, w;
    obs_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(l);
    check({tag, "_busy"}, 32'(busy), 32'(1));
    check({tag, "_cmd_ready_low"}, 32'(cmd_ready), 32'(0));
    check({tag, "_s_ready_pre_data"}, 32'(s_ready), 32'(0));
    foreach (hw_q[i]) send_hw(hw_q[i], (i == last_at), gap);
    w = 0;
    while (done_cnt == d0 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(1));
    check({tag, "_err_pulses"}, 32'(err_cnt - e0), 32'(err_exp));
    check({tag, "_idle_ready"}, {30'h0, cmd_ready, busy}, 32'h2);
    exp_q.delete();
    exp_q.push_back({2'b00, 16'h00F8});
    foreach (hw_q[i]) exp_q.push_back({2'b01, hw_q[i]});
    exp_q.push_back({2'b00, 16'h00FC});
    exp_q.push_back({2'b01, 8'h00, l[7:0]});
    exp_q.push_back({2'b00, 16'h00FD});
    exp_q.push_back({2'b01, 8'h00, l[15:8]});
    exp_q.push_back({2'b00, 16'h0002});
    exp_q.push_back({2'b01, 16'h0001});
    exp_q.push_back({2'b00, 16'h0002});
    repeat (nreads) exp_q.push_back({2'b11, 16'h0000});
    check({tag, "_txn_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_txn%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic reject(input string tag, input logic [15:0] l);
    int r0, e0;
    r0 = req_cnt;
    e0 = err_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_err_next_cycle"}, {30'h0, err, done}, 32'h2);
    check({tag, "_cmd_ready"}, {30'h0, cmd_ready, busy}, 32'h2);
    @(negedge clk);
    check({tag, "_err_one_cycle"}, 32'(err), 32'(0));
    repeat (6) @(negedge clk);
    check({tag, "_no_bus"}, 32'(req_cnt - r0), 32'(0));
    check({tag, "_err_total"}, 32'(err_cnt - e0), 32'(1));
    check({tag, "_still_idle"}, {30'h0, cmd_ready, busy}, 32'h2);
  endtask

  initial begin
    int b, d0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_flags", {29'h0, busy, done, err}, 32'h0);
    check("rst_bus_req", {30'h0, bus_if.bus_write, bus_if.bus_read}, 32'h0);
    check("rst_s_ready", 32'(s_ready), 32'(0));
    check("rst_bus_addr", bus_if.bus_address, 32'h0);
    check("rst_bus_data", bus_if.bus_data_wr, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame, TCR busy once then clear.
    stall_cycles = 1;
    hw_q = '{16'h1122, 16'h3344};
    rd_q = '{16'h0001, 16'h0000};
    run_frame("len4", 16'd4, 0, 1, 2, 0);

    // Same frame under long stalls and stream gaps.
    stall_cycles = 12;
    rd_q = '{16'h0001, 16'h0000};
    run_frame("len4_slow", 16'd4, 3, 1, 2, 0);

    // Odd length: three halfwords, TXPLL = 5.
    stall_cycles = 1;
    hw_q = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
    run_frame("len5", 16'd5, 2, 2, 1, 0);

    reject("len0", 16'd0);
    reject("len1537", 16'd1537);

    // Length-check mismatches: early s_last, and s_last never asserted.
    hw_q = '{16'h5A5A, 16'hA5A5};
    run_frame("early_last", 16'd4, 0, 0, 1, 1);
    run_frame("no_last", 16'd3, 1, -1, 1, 1);

    // Completion poll timeout.
    rd_stuck = 1'b1;
    hw_q = '{16'h0BEE};
    run_frame("poll_stuck", 16'd2, 0, 0, 8, 1);
    rd_stuck = 1'b0;

    // Largest legal frame.
    hw_q.delete();
    for (int i = 0; i < 768; i++) hw_q.push_back(16'(i * 3 + 7));
    run_frame("len1536", 16'd1536, 0, 767, 1, 0);

    // Reset while a data write is outstanding.
    stall_cycles = 12;
    send_cmd(16'd4);
    s_valid = 1'b1;
    s_data = 16'hDEAD;
    s_last = 1'b0;
    b = 0;
    while (!(bus_if.bus_write && dbg_state == 4'd2) && b < 500) begin
      @(negedge clk);
      b++;
    end
    check("rst_mid_reached_data", 32'(b < 500), 32'(1));
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_write_drop", {30'h0, bus_if.bus_write, bus_if.bus_read}, 32'h0);
    check("rst_mid_idle", {30'h0, cmd_ready, busy}, 32'h2);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'(0));

    // Engine recovers after the abandoned frame.
    stall_cycles = 1;
    hw_q = '{16'h7788};
    run_frame("after_rst", 16'd1, 0, 0, 1, 0);

    check("protocol_violations", 32'(proto_bad), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
